delay_line_ctrl: RTL and testbench

Streaming controller that turns one dual_port_ram instance into a programmable-length sample delay line.
- Each accepted input sample is written at a circular write pointer.
- In the same cycle, the sample written D accepts earlier is read out.
- Valid/ready handshakes on both sides; zero-fill clear sequencing after reset and on every delay reconfiguration.
- Sits between the sample source (ADC/deserialiser) and downstream DSP in the delay-line datapath.

---
 rtl/delay_line_pkg.sv | 18 +
 rtl/delay_line_ctrl_if.sv | 35 +++
 rtl/dual_port_ram.sv | 31 +++
 rtl/delay_line_ctrl.sv | 150 +++++++++++++++
 tb/tb_delay_line_ctrl.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/delay_line_pkg.sv
// ---------------------------------------------------------------------------
// delay_line_pkg
// Shared types and defaults for the delay_line_ctrl block.
//   state_t     : controller state (ST_CLEAR zero-fills the RAM, ST_RUN streams)
//   DEF_WIDTH   : default sample width in bits
//   DEF_DEPTH   : default RAM depth in samples (power of two, >= 4)
// ---------------------------------------------------------------------------
package delay_line_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 256;

endpackage

// File: rtl/delay_line_ctrl_if.sv
// ---------------------------------------------------------------------------
// delay_line_ctrl_if
// Sample stream bundle for the delay line: an input stream into the
// controller and a delayed output stream out of it.
//   in_data/in_valid/in_ready    : input sample stream
//   out_data/out_valid/out_ready : delayed sample stream
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high. A source holds data stable and keeps valid asserted until the
// transfer; ready may depend combinationally on the sink's own state.
// Modports:
//   master : sample source / downstream sink side (the environment)
//   slave  : the delay line controller
// ---------------------------------------------------------------------------
interface delay_line_ctrl_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

endinterface

// File: rtl/dual_port_ram.sv
// ---------------------------------------------------------------------------
// dual_port_ram
// Simple dual-port RAM: one synchronous write port, one synchronous read port
// with enable. rd_data holds its value while rd_en is low.
// Ports:
//   clk                       : clock
//   wr_en, wr_addr, wr_data   : write port
//   rd_en, rd_addr, rd_data   : read port (one cycle read latency)
// ---------------------------------------------------------------------------
module dual_port_ram #(
  parameter int  WIDTH      = 8,
  parameter int  DEPTH      = 256,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/delay_line_ctrl.sv
// ---------------------------------------------------------------------------
// delay_line_ctrl
// Turns one dual_port_ram into a programmable-length sample delay line. Each
// accepted sample is written at a circular write pointer while the sample
// written D accepts earlier is read out in the same cycle.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   cfg_delay  : requested delay D in samples (0 behaves as 1)
//   cfg_load   : one-cycle pulse, latch cfg_delay, flush and restart
//   bus        : delay_line_ctrl_if.slave (in_* and out_* sample streams)
//   busy       : high while zero-filling the RAM
//   state      : current controller state (debug visibility)
// Optional feature macro: DELAY_LINE_CLEAR_EN
//   defined   : reset / cfg_load zero-fill the whole RAM before streaming
//   undefined : no clear sequence, busy tied 0; the first D outputs after
//               reset or reconfiguration are stale RAM contents
// ---------------------------------------------------------------------------
module delay_line_ctrl
  import delay_line_pkg::*;
#(
  parameter int  WIDTH         = DEF_WIDTH,
  parameter int  DEPTH         = DEF_DEPTH,
  parameter int  DEFAULT_DELAY = 1,
  localparam int ADDR_WIDTH    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] cfg_delay,
  input  logic                  cfg_load,
  delay_line_ctrl_if.slave      bus,
  output logic                  busy,
  output state_t                state
);

  logic [ADDR_WIDTH-1:0] wptr_q;
  logic [ADDR_WIDTH-1:0] delay_q;
  logic [ADDR_WIDTH-1:0] load_delay;
  logic                  out_valid_q;
  logic                  run;
  logic                  clearing;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  in_rdy;
  logic                  accept;

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [WIDTH-1:0]      wr_data;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [WIDTH-1:0]      rd_data;

  // A zero delay would read the slot being written; clamp it to one.
  assign load_delay = (cfg_delay == '0) ? ADDR_WIDTH'(1) : cfg_delay;

`ifdef DELAY_LINE_CLEAR_EN
  state_t                state_q;
  state_t                state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_CLEAR;
    else     state_q <= state_d;
  end

  // Clear counter wraps to 0 naturally after address DEPTH-1.
  always_ff @(posedge clk) begin
    if (rst || cfg_load)          clr_cnt_q <= '0;
    else if (state_q == ST_CLEAR) clr_cnt_q <= clr_cnt_q + 1'b1;
  end

  // Next-state logic; cfg_load overrides everything and restarts the clear.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR: if (clr_cnt_q == ADDR_WIDTH'(DEPTH - 1)) state_d = ST_RUN;
      ST_RUN:   state_d = ST_RUN;
      default:  state_d = ST_CLEAR;
    endcase
    if (cfg_load) state_d = ST_CLEAR;
  end

  assign state    = state_q;
  assign run      = (state_q == ST_RUN);
  assign clearing = (state_q == ST_CLEAR);
  assign clr_addr = clr_cnt_q;
`else
  assign state    = ST_RUN;
  assign run      = 1'b1;
  assign clearing = 1'b0;
  assign clr_addr = '0;
`endif

  // Output logic: handshake and RAM port control.
  always_comb begin
    in_rdy  = run && (!out_valid_q || bus.out_ready);
    accept  = bus.in_valid && in_rdy;
    wr_en   = accept;
    wr_addr = wptr_q;
    wr_data = bus.in_data;
    rd_en   = accept;
    // Natural ADDR_WIDTH-bit wrap gives the circular read address.
    rd_addr = wptr_q - delay_q;
    if (clearing) begin
      wr_en   = 1'b1;
      wr_addr = clr_addr;
      wr_data = '0;
    end
  end

  // Pointer, active delay and output-valid tracking. A transfer accepted in
  // the same cycle as cfg_load is still written to RAM but is then discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      delay_q     <= ADDR_WIDTH'(DEFAULT_DELAY);
      out_valid_q <= 1'b0;
    end else if (cfg_load) begin
      wptr_q      <= '0;
      delay_q     <= load_delay;
      out_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        wptr_q      <= wptr_q + 1'b1;
        out_valid_q <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = rd_data;
  assign busy          = clearing;

  dual_port_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_delay_line_ctrl.sv
// ---------------------------------------------------------------------------
// tb_delay_line_ctrl
// Directed bench for delay_line_ctrl with DEPTH=16, WIDTH=8. Stimulus pushes
// the hand-computed delayed sample into exp_q; a monitor pops and compares
// every output transfer. Without DELAY_LINE_CLEAR_EN the first D outputs after
// a (re)configuration are stale RAM contents and are only consumed, not
// compared.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_delay_line_ctrl;
  import delay_line_pkg::*;

  localparam int W     = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
`ifdef DELAY_LINE_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif
  localparam int CLR_CYCLES = CLEAR_EN ? DEPTH : 0;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] cfg_delay;
  logic          cfg_load;
  logic          busy;
  state_t        state;

  always #5 clk = ~clk;

  delay_line_ctrl_if #(.WIDTH(W)) bus ();

  delay_line_ctrl #(
    .WIDTH         (W),
    .DEPTH         (DEPTH),
    .DEFAULT_DELAY (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_delay (cfg_delay),
    .cfg_load  (cfg_load),
    .bus       (bus),
    .busy      (busy),
    .state     (state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  bit           chk_q[$];
  int           checks = 0;
  int           errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: one output transfer per clock edge where out_valid && out_ready.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %0h expected none", bus.out_data);
      end else begin
        logic [W-1:0] e;
        bit           k;
        e = exp_q.pop_front();
        k = chk_q.pop_front();
        if (k) check("out_data", {24'd0, bus.out_data}, {24'd0, e});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All drivers are entered and return at posedge + 1.
  task automatic send(input logic [W-1:0] d);
    int  n = 0;
    bit  acc;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    forever begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk); #1;
      if (acc) break;
      n++;
      if (n > 200) begin
        check("send_timeout", 32'd1, 32'd0);
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic issue(input logic [W-1:0] d, input logic [W-1:0] e, input bit known);
    exp_q.push_back(e);
    chk_q.push_back(known);
    send(d);
  endtask

  task automatic do_load(input logic [AW-1:0] d);
    cfg_delay = d;
    cfg_load  = 1'b1;
    @(posedge clk); #1;
    cfg_load  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n   = 0;
    int bad = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 200) begin
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) bad++;
      n++;
      @(negedge clk);
    end
    check({name, "_busy_cycles"}, n, CLR_CYCLES);
    check({name, "_ready_low_while_busy"}, bad, 0);
    check({name, "_in_ready_after"}, {31'd0, bus.in_ready}, 32'd1);
    check({name, "_state_run"}, {31'd0, state}, {31'd0, ST_RUN});
    @(posedge clk); #1;
  endtask

  task automatic drain();
    repeat (3) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] tbl_d3 [8] = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
  logic [W-1:0] tbl_d1 [3] = '{8'd0, 8'd7, 8'd8};
  logic [W-1:0] tbl_d2 [3] = '{8'd0, 8'd0, 8'd4};
  logic [W-1:0] rnd    [40];

  initial begin
    int stall_bad;
    rst          = 1'b1;
    cfg_delay    = '0;
    cfg_load     = 1'b0;
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("reset_busy", {31'd0, busy}, {31'd0, CLEAR_EN});
    rst = 1'b0;
    wait_idle("reset");

    // Delay 3, stream 1..8, outputs one cycle after each accept
    do_load(4'd3);
    wait_idle("load3");
    for (int i = 0; i < 8; i++) begin
      issue(W'(i + 1), tbl_d3[i], CLEAR_EN || i >= 3);
      check("latency_d3", {31'd0, bus.out_valid}, 32'd1);
    end
    drain();

    // Same stream with a 5-cycle downstream stall after sample 4
    do_load(4'd3);
    wait_idle("load3b");
    for (int i = 0; i < 4; i++) issue(W'(i + 1), tbl_d3[i], CLEAR_EN || i >= 3);
    bus.out_ready = 1'b0;
    bus.in_data   = 8'd5;
    bus.in_valid  = 1'b1;
    stall_bad     = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== 8'd1) stall_bad++;
    end
    @(posedge clk); #1;
    check("stall_hold", stall_bad, 0);
    bus.out_ready = 1'b1;
    for (int i = 4; i < 8; i++) issue(W'(i + 1), tbl_d3[i], 1'b1);
    drain();

    // cfg_delay = 0 behaves as delay 1
    do_load(4'd0);
    wait_idle("load0");
    for (int i = 0; i < 3; i++) begin
      issue(W'(i + 7), tbl_d1[i], CLEAR_EN || i >= 1);
      check("latency_d1", {31'd0, bus.out_valid}, 32'd1);
    end
    drain();

    // Delay 15 across pointer wrap with random samples
    do_load(4'd15);
    wait_idle("load15");
    for (int i = 0; i < 40; i++) rnd[i] = W'($urandom_range(1, 255));
    for (int i = 0; i < 40; i++)
      issue(rnd[i], (i >= 15) ? rnd[i - 15] : 8'd0, CLEAR_EN || i >= 15);

    // Reconfigure while an output is pending and blocked; it must be dropped
    bus.out_ready = 1'b0;
    check("pre_load_out_valid", {31'd0, bus.out_valid}, 32'd1);
    void'(exp_q.pop_back());
    void'(chk_q.pop_back());
    do_load(4'd2);
    check("load_drops_out_valid", {31'd0, bus.out_valid}, 32'd0);
    wait_idle("load2");
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) issue(W'(i + 4), tbl_d2[i], CLEAR_EN || i >= 2);
    drain();

    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
